// File: rtl/clut_pkg.sv
// clut_pkg: shared definitions for the programmable colour look-up table.
//   - default "cat" palette entries in RGB444
//   - FSM state encoding for the palette loader
//   - clut_default(): RGB444 default colour for a palette index
package clut_pkg;

    localparam logic [11:0] CAT_ORANGE = 12'hF80;
    localparam logic [11:0] CAT_CREAM  = 12'hFC7;
    localparam logic [11:0] CAT_WHITE  = 12'hFFF;
    localparam logic [11:0] CAT_PINK   = 12'hFBE;
    localparam logic [11:0] CAT_NOSE   = 12'hF6D;
    localparam logic [11:0] CAT_BLACK  = 12'h000;
    localparam logic [11:0] CAT_EYE    = 12'h06B;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } clut_state_t;

    // Entries beyond the cat colours default to black.
    function automatic logic [11:0] clut_default(input int unsigned idx);
        case (idx)
            0:       clut_default = CAT_ORANGE;
            1:       clut_default = CAT_CREAM;
            2:       clut_default = CAT_WHITE;
            3:       clut_default = CAT_PINK;
            4:       clut_default = CAT_NOSE;
            5:       clut_default = CAT_BLACK;
            6:       clut_default = CAT_EYE;
            default: clut_default = 12'h000;
        endcase
    endfunction

endpackage

// File: rtl/clut_regfile.sv
// clut_regfile: palette storage, one write port and one registered read port.
// A read and a write to the same entry on the same edge returns the old colour.
// Ports:
//   clk, rst_n   clock, async active-low reset (read register only)
//   we/waddr/wdata  write port
//   re/raddr        read request; rdata updates one edge later, holds otherwise
//   rdata           registered read data
module clut_regfile #(
    parameter int AW = 4,
    parameter int DW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    // Storage is not reset: the loader rewrites every entry after each reset.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/clut_prog.sv
// clut_prog: programmable colour look-up table with default palette loader.
// After reset the loader writes the default cat palette (one entry per cycle),
// then the block accepts lookups (latency 1) and palette writes.
// Optional feature: define CLUT_TRANSP_EN to flag lookups of TRANSP_IDX on pix_transp.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   pix_valid, pix_index          lookup request
//   pix_colr, pix_colr_vld        registered colour result and its valid
//   pix_transp                    result index is TRANSP_IDX (0 when feature off)
//   wr_valid, wr_ready, wr_addr, wr_data   palette write handshake
//   init_done                     default palette loaded
//
// state   | meaning
// --------+-----------------------------------------------------
// ST_INIT | loading default palette, ptr walks 0..2**IDX_W-1
// ST_RUN  | lookups and software writes accepted
module clut_prog
    import clut_pkg::*;
#(
    parameter int IDX_W      = 4,
    parameter int COL_W      = 12,
    parameter int TRANSP_IDX = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_valid,
    input  logic [IDX_W-1:0] pix_index,
    output logic [COL_W-1:0] pix_colr,
    output logic             pix_colr_vld,
    output logic             pix_transp,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [COL_W-1:0] wr_data,
    output logic             init_done
);

    localparam int CH_W = COL_W / 3;

    // Stretch RGB444 to COL_W: each nibble sits at the top of its channel.
    function automatic logic [COL_W-1:0] widen(input logic [11:0] c);
        logic [COL_W-1:0] w;
        w = '0;
        w[COL_W-1  -: 4] = c[11:8];
        w[2*CH_W-1 -: 4] = c[7:4];
        w[CH_W-1   -: 4] = c[3:0];
        return w;
    endfunction

    clut_state_t      state, state_nxt;
    logic [IDX_W-1:0] ptr, ptr_nxt;

    logic             rf_we;
    logic [IDX_W-1:0] rf_waddr;
    logic [COL_W-1:0] rf_wdata;
    logic             rf_re;
    logic             run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_INIT;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        case (state)
            ST_INIT: begin
                ptr_nxt = ptr + 1'b1;
                if (&ptr) state_nxt = ST_RUN;
            end
            ST_RUN:  state_nxt = ST_RUN;
            default: state_nxt = ST_INIT;
        endcase
    end

    assign run       = (state == ST_RUN);
    assign init_done = run;
    assign wr_ready  = run;

    // Loader owns the write port during INIT; software owns it afterwards.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = wr_addr;
        rf_wdata = wr_data;
        if (!run) begin
            rf_we    = 1'b1;
            rf_waddr = ptr;
            rf_wdata = widen(clut_default(32'(ptr)));
        end else begin
            rf_we    = wr_valid;
        end
    end

    assign rf_re = pix_valid & run;

    clut_regfile #(
        .AW (IDX_W),
        .DW (COL_W)
    ) u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (rf_we),
        .waddr (rf_waddr),
        .wdata (rf_wdata),
        .re    (rf_re),
        .raddr (pix_index),
        .rdata (pix_colr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pix_colr_vld <= 1'b0;
        else        pix_colr_vld <= rf_re;
    end

`ifdef CLUT_TRANSP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     pix_transp <= 1'b0;
        else if (rf_re) pix_transp <= (pix_index == IDX_W'(TRANSP_IDX));
        else            pix_transp <= 1'b0;
    end
`else
    assign pix_transp = 1'b0;
`endif

endmodule

// File: tb/tb_clut_prog.sv
// Scoreboard bench for clut_prog: lookups push expected results, a negedge
// monitor pops and compares whenever pix_colr_vld is seen.
module tb_clut_prog;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pix_valid;
    logic [3:0]  pix_index;
    logic [11:0] pix_colr;
    logic        pix_colr_vld;
    logic        pix_transp;
    logic        wr_valid;
    logic        wr_ready;
    logic [3:0]  wr_addr;
    logic [11:0] wr_data;
    logic        init_done;

    typedef struct packed {
        logic [11:0] colr;
        logic        tr;
        logic [3:0]  idx;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    clut_prog dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pix_valid    (pix_valid),
        .pix_index    (pix_index),
        .pix_colr     (pix_colr),
        .pix_colr_vld (pix_colr_vld),
        .pix_transp   (pix_transp),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .init_done    (init_done)
    );

    function automatic logic exp_tr(input logic [3:0] idx);
`ifdef CLUT_TRANSP_EN
        return idx == 4'd6;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every valid result must match the oldest outstanding lookup.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && pix_colr_vld === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_vld", 32'(pix_colr), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check($sformatf("colr_idx%0d", e.idx), 32'(pix_colr), 32'(e.colr));
                    check($sformatf("transp_idx%0d", e.idx), 32'(pix_transp), 32'(e.tr));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic lookup(input logic [3:0] idx, input logic [11:0] colr);
        pix_valid = 1'b1;
        pix_index = idx;
        exp_q.push_back('{colr: colr, tr: exp_tr(idx), idx: idx});
        @(posedge clk); #1;
        pix_valid = 1'b0;
    endtask

    task automatic write(input logic [3:0] a, input logic [11:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        @(posedge clk); #1;
        wr_valid = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check("rst_colr", 32'(pix_colr), 0);
        check("rst_vld", 32'(pix_colr_vld), 0);
        check("rst_transp", 32'(pix_transp), 0);
        check("rst_init_done", 32'(init_done), 0);
        check("rst_wr_ready", 32'(wr_ready), 0);
    endtask

    // Called just after rst_n release; holds a lookup of idx 2 throughout INIT
    // (must be ignored), then issues idx 0 on the first RUN cycle.
    task automatic wait_init();
        int cyc;
        cyc = 0;
        pix_valid = 1'b1;
        pix_index = 4'd2;
        wr_valid  = 1'b1;
        wr_addr   = 4'd1;
        wr_data   = 12'hBAD;
        while (cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (init_done === 1'b1) break;
            check("init_wr_ready", 32'(wr_ready), 0);
        end
        wr_valid = 1'b0;
        check("init_cycles", 32'(cyc), 16);
        lookup(4'd0, 12'hF80);
    endtask

    initial begin
        rst_n     = 1'b0;
        pix_valid = 1'b0;
        pix_index = '0;
        wr_valid  = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst_n = 1'b1;

        // Tests 1 and 2
        wait_init();
        lookup(4'd2, 12'hFFF);
        lookup(4'd1, 12'hFC7);
        lookup(4'd3, 12'hFBE);
        lookup(4'd4, 12'hF6D);
        lookup(4'd15, 12'h000);
        check("run_wr_ready", 32'(wr_ready), 1);

        // Test 3 plus hold behaviour
        write(4'd7, 12'h0F0);
        lookup(4'd7, 12'h0F0);
        @(negedge clk);
        @(negedge clk);
        check("hold_colr", 32'(pix_colr), 32'h0F0);
        check("hold_vld", 32'(pix_colr_vld), 0);
        @(posedge clk); #1;
        lookup(4'd8, 12'h000);

        // Test 4: read-before-write on the same entry
        wr_valid  = 1'b1;
        wr_addr   = 4'd0;
        wr_data   = 12'h123;
        pix_valid = 1'b1;
        pix_index = 4'd0;
        exp_q.push_back('{colr: 12'hF80, tr: 1'b0, idx: 4'd0});
        @(posedge clk); #1;
        wr_valid  = 1'b0;
        pix_valid = 1'b0;
        lookup(4'd0, 12'h123);

        // Back-to-back writes, then back-to-back lookups
        write(4'd9, 12'hAAA);
        write(4'd10, 12'hBBB);
        lookup(4'd9, 12'hAAA);
        lookup(4'd10, 12'hBBB);

        // Test 6
        lookup(4'd6, 12'h06B);
        lookup(4'd5, 12'h000);

        // Test 5: overwrite entry 1, reset, pulse reset again at INIT cycle 5
        write(4'd1, 12'h555);
        lookup(4'd1, 12'h555);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        check_reset_outputs();
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        check("midinit_init_done", 32'(init_done), 0);
        check("midinit_vld", 32'(pix_colr_vld), 0);
        rst_n = 1'b1;
        wait_init();
        lookup(4'd1, 12'hFC7);
        lookup(4'd7, 12'h000);
        lookup(4'd9, 12'h000);
        lookup(4'd6, 12'h06B);

        repeat (3) @(posedge clk);
        check("queue_drained", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
